// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-side pipeline blocks.
package mips_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned OP_W   = 2;

    localparam logic [OP_W-1:0] OP_JUMP = 2'b11;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HALT   = 2'd2
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer.sv
// Program counter sequencer: PC+1 / jump redirect with stall, one-cycle post-jump bubble,
// and halt once the PC leaves the loaded program.
module pc_sequencer
    import mips_pkg::OP_W, mips_pkg::OP_JUMP;
    import mips_pkg::seq_state_e, mips_pkg::RUN, mips_pkg::BUBBLE, mips_pkg::HALT;
#(
    parameter int unsigned          ADDR_W    = mips_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
    parameter logic [ADDR_W-1:0]    PROG_LAST = ADDR_W'(5),
    parameter int unsigned          CNT_W     = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic [OP_W-1:0]   opcode,
    input  logic [ADDR_W-1:0] jump_address,
    output logic [ADDR_W-1:0] instruction_address,
    output logic              fetch_valid,
    output logic              jump_taken,
    output logic              halted,
    output logic [CNT_W-1:0]  jump_count
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              jump_taken_q, jump_taken_d;
    logic [CNT_W-1:0]  jump_count_q, jump_count_d;
    logic [ADDR_W-1:0] pc_inc;

    assign pc_inc = pc_q + ADDR_W'(1);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        jump_taken_d = 1'b0;
        jump_count_d = jump_count_q;

        case (state_q)
            RUN: begin
                if (!stall) begin
                    if (opcode == OP_JUMP) begin
                        pc_d = jump_address;
                        if (jump_count_q != '1) begin
                            jump_count_d = jump_count_q + CNT_W'(1);
                        end
                        // A jump out of the program is counted but goes straight to HALT,
                        // so no redirect pulse is raised while halted.
                        if (jump_address > PROG_LAST) begin
                            state_d = HALT;
                        end else begin
                            state_d      = BUBBLE;
                            jump_taken_d = 1'b1;
                        end
                    end else begin
                        pc_d    = pc_inc;
                        state_d = (pc_inc > PROG_LAST) ? HALT : RUN;
                    end
                end
            end
            BUBBLE: begin
                if (!stall) begin
                    state_d = RUN;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            jump_taken_q <= 1'b0;
            jump_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            jump_taken_q <= jump_taken_d;
            jump_count_q <= jump_count_d;
        end
    end

    assign instruction_address = pc_q;
    assign fetch_valid         = (state_q == RUN);
    assign halted              = (state_q == HALT);
    assign jump_taken          = jump_taken_q;
    assign jump_count          = jump_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: default instance plus a wrap-around instance.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       stall;
    logic [1:0] opcode;
    logic [7:0] jump_address;
    logic [7:0] pc;
    logic       fv, jt, hlt;
    logic [3:0] cnt;

    logic       w_reset_n;
    logic       w_stall;
    logic [1:0] w_opcode;
    logic [7:0] w_jump_address;
    logic [7:0] w_pc;
    logic       w_fv, w_jt, w_hlt;
    logic [3:0] w_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_sequencer u_dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .stall               (stall),
        .opcode              (opcode),
        .jump_address        (jump_address),
        .instruction_address (pc),
        .fetch_valid         (fv),
        .jump_taken          (jt),
        .halted              (hlt),
        .jump_count          (cnt)
    );

    pc_sequencer #(
        .ADDR_W    (8),
        .RESET_PC  (8'hFF),
        .PROG_LAST (8'hFF),
        .CNT_W     (4)
    ) u_wrap (
        .clk                 (clk),
        .reset_n             (w_reset_n),
        .stall               (w_stall),
        .opcode              (w_opcode),
        .jump_address        (w_jump_address),
        .instruction_address (w_pc),
        .fetch_valid         (w_fv),
        .jump_taken          (w_jt),
        .halted              (w_hlt),
        .jump_count          (w_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_pc, input logic e_fv,
                           input logic e_jt, input logic e_hlt, input logic [3:0] e_cnt);
        check({tag, ".pc"},     32'(pc),  32'(e_pc));
        check({tag, ".fv"},     32'(fv),  32'(e_fv));
        check({tag, ".jt"},     32'(jt),  32'(e_jt));
        check({tag, ".halted"}, 32'(hlt), 32'(e_hlt));
        check({tag, ".cnt"},    32'(cnt), 32'(e_cnt));
    endtask

    // Advance one clock; sampling happens 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #2;
        chk_all(tag, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; stall = 1'b0; opcode = 2'b00; jump_address = 8'h00;
        w_reset_n = 1'b0; w_stall = 1'b0; w_opcode = 2'b00; w_jump_address = 8'h00;
        #12;

        // Test 1: sequential fetch 0..5
        do_reset("t1_reset");
        for (int i = 1; i <= 5; i++) begin
            opcode = 2'(i % 3);
            cyc();
            chk_all("t1_seq", 8'(i), 1'b1, 1'b0, 1'b0, 4'h0);
        end

        // Test 4: run past PROG_LAST, then frozen regardless of opcode
        opcode = 2'b00;
        cyc();
        chk_all("t4_halt", 8'h06, 1'b0, 1'b0, 1'b1, 4'h0);
        opcode = 2'b11; jump_address = 8'h01;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk_all("t4_frozen", 8'h06, 1'b0, 1'b0, 1'b1, 4'h0);
        end

        // Test 2: jump at PC=3 to 1
        opcode = 2'b00;
        do_reset("t2_reset");
        cyc(); cyc(); cyc();
        chk_all("t2_pc3", 8'h03, 1'b1, 1'b0, 1'b0, 4'h0);
        opcode = 2'b11; jump_address = 8'h01;
        cyc();
        chk_all("t2_jump", 8'h01, 1'b0, 1'b1, 1'b0, 4'h1);
        cyc();
        chk_all("t2_bubble_end", 8'h01, 1'b1, 1'b0, 1'b0, 4'h1);
        opcode = 2'b00;
        cyc();
        chk_all("t2_resume", 8'h02, 1'b1, 1'b0, 1'b0, 4'h1);

        // Test 3: stall holds a pending jump at PC=3
        cyc();
        chk_all("t3_pc3", 8'h03, 1'b1, 1'b0, 1'b0, 4'h1);
        stall = 1'b1; opcode = 2'b11; jump_address = 8'h01;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_all("t3_stalled", 8'h03, 1'b1, 1'b0, 1'b0, 4'h1);
        end
        stall = 1'b0;
        cyc();
        chk_all("t3_release", 8'h01, 1'b0, 1'b1, 1'b0, 4'h2);
        stall = 1'b1;
        cyc();
        chk_all("t3_bubble_stall", 8'h01, 1'b0, 1'b0, 1'b0, 4'h2);
        stall = 1'b0; opcode = 2'b00;
        cyc();
        chk_all("t3_bubble_exit", 8'h01, 1'b1, 1'b0, 1'b0, 4'h2);

        // Test 6a: async reset in the middle of a bubble
        cyc();
        chk_all("t6_pc2", 8'h02, 1'b1, 1'b0, 1'b0, 4'h2);
        opcode = 2'b11; jump_address = 8'h04;
        cyc();
        chk_all("t6_in_bubble", 8'h04, 1'b0, 1'b1, 1'b0, 4'h3);
        #2;
        do_reset("t6_async_reset");

        // Test 6b: self-loop at PC=0 saturates the jump counter
        opcode = 2'b11; jump_address = 8'h00;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            chk_all("t6_loop_jump", 8'h00, 1'b0, 1'b1, 1'b0, (k > 15) ? 4'hF : 4'(k));
            cyc();
            chk_all("t6_loop_run", 8'h00, 1'b1, 1'b0, 1'b0, (k > 15) ? 4'hF : 4'(k));
        end

        // Test 5: RESET_PC=FF with PROG_LAST=FF wraps to 00 and stays running
        check("t5_reset_pc", 32'(w_pc), 32'h0000_00FF);
        check("t5_reset_fv", 32'(w_fv), 32'h1);
        w_reset_n = 1'b1;
        cyc();
        check("t5_wrap_pc",     32'(w_pc),  32'h0);
        check("t5_wrap_fv",     32'(w_fv),  32'h1);
        check("t5_wrap_halted", 32'(w_hlt), 32'h0);
        cyc();
        check("t5_after_wrap_pc", 32'(w_pc), 32'h1);
        check("t5_after_wrap_jt", 32'(w_jt), 32'h0);
        check("t5_cnt",           32'(w_cnt), 32'h0);
        w_stall = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
